// File: rtl/y_signature_checker.sv
// Response-side signature checker: compacts sampled y words into a 32-bit MISR,
// compares against a golden signature after a fixed sample count, and flags stalls.
module y_signature_checker #(
    parameter int          Y_WIDTH     = 152,
    parameter int          NUM_VECTORS = 20,
    parameter logic [31:0] SEED        = 32'hFFFF_FFFF,
    parameter logic [31:0] POLY        = 32'h04C1_1DB7,
    parameter int          TIMEOUT     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Y_WIDTH-1:0] y_in,
    input  logic               y_valid,
    input  logic [31:0]        golden_sig,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               fail,
    output logic               timeout,
    output logic [31:0]        signature,
    output logic [15:0]        vec_count
);

    localparam int          CHUNKS   = (Y_WIDTH + 31) / 32;
    localparam logic [16:0] LAST     = 17'(NUM_VECTORS);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t      state, state_next;
    logic [31:0] sig_next;
    logic [15:0] cnt_next;
    logic [31:0] idle_cnt, idle_next;
    logic        pass_next, fail_next, to_next;

    // XOR of all 32-bit chunks of the zero-extended response word.
    function automatic logic [31:0] fold(input logic [Y_WIDTH-1:0] y);
        logic [CHUNKS*32-1:0] ext;
        logic [31:0]          f;
        ext = '0;
        ext[Y_WIDTH-1:0] = y;
        f = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            f ^= ext[32*i +: 32];
        end
        return f;
    endfunction

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_next = state;
        sig_next   = signature;
        cnt_next   = vec_count;
        idle_next  = idle_cnt;
        pass_next  = pass;
        fail_next  = fail;
        to_next    = timeout;
        if (start) begin
            // Restart from any state; a sample arriving with start is dropped.
            state_next = RUN;
            sig_next   = SEED;
            cnt_next   = '0;
            idle_next  = '0;
            pass_next  = 1'b0;
            fail_next  = 1'b0;
            to_next    = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (y_valid) begin
                        sig_next  = misr_step(signature, fold(y_in));
                        cnt_next  = sat_inc16(vec_count);
                        idle_next = '0;
                        if ({1'b0, vec_count} + 17'd1 == LAST) state_next = CHECK;
                    end else begin
                        idle_next = sat_inc32(idle_cnt);
                        if (TIMEOUT != 0 && idle_cnt + 32'd1 == TO_LIMIT) begin
                            state_next = DONE;
                            pass_next  = 1'b0;
                            fail_next  = 1'b1;
                            to_next    = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    pass_next  = (signature == golden_sig);
                    fail_next  = (signature != golden_sig);
                    state_next = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            signature <= SEED;
            vec_count <= '0;
            idle_cnt  <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            signature <= sig_next;
            vec_count <= cnt_next;
            idle_cnt  <= idle_next;
            pass      <= pass_next;
            fail      <= fail_next;
            timeout   <= to_next;
        end
    end

    assign busy = (state == RUN) || (state == CHECK);
    assign done = (state == DONE);

endmodule

// File: tb/tb_y_signature_checker.sv
// Bench for y_signature_checker: four differently parameterised instances share one
// stimulus bus; directed tables, hand sequences and a randomized model comparison.
module tb_y_signature_checker;

    localparam int M = 0, Z20 = 1, Z2 = 2, HI = 3;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] SEED_M = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [151:0] y_in;
    logic         y_valid;
    logic [31:0]  golden_sig;
    logic         start_i [4];
    logic         busy_o [4], done_o [4], pass_o [4], fail_o [4], to_o [4];
    logic [31:0]  sig_o [4];
    logic [15:0]  cnt_o [4];

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    y_signature_checker #(.TIMEOUT(16)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start_i[M]), .y_in(y_in), .y_valid(y_valid),
        .golden_sig(golden_sig), .busy(busy_o[M]), .done(done_o[M]), .pass(pass_o[M]),
        .fail(fail_o[M]), .timeout(to_o[M]), .signature(sig_o[M]), .vec_count(cnt_o[M]));

    y_signature_checker #(.SEED(32'h0), .NUM_VECTORS(20)) u_z20 (
        .clk(clk), .rst_n(rst_n), .start(start_i[Z20]), .y_in(y_in), .y_valid(y_valid),
        .golden_sig(golden_sig), .busy(busy_o[Z20]), .done(done_o[Z20]), .pass(pass_o[Z20]),
        .fail(fail_o[Z20]), .timeout(to_o[Z20]), .signature(sig_o[Z20]), .vec_count(cnt_o[Z20]));

    y_signature_checker #(.SEED(32'h0), .NUM_VECTORS(2)) u_z2 (
        .clk(clk), .rst_n(rst_n), .start(start_i[Z2]), .y_in(y_in), .y_valid(y_valid),
        .golden_sig(golden_sig), .busy(busy_o[Z2]), .done(done_o[Z2]), .pass(pass_o[Z2]),
        .fail(fail_o[Z2]), .timeout(to_o[Z2]), .signature(sig_o[Z2]), .vec_count(cnt_o[Z2]));

    y_signature_checker #(.SEED(32'h8000_0000), .NUM_VECTORS(1)) u_hi (
        .clk(clk), .rst_n(rst_n), .start(start_i[HI]), .y_in(y_in), .y_valid(y_valid),
        .golden_sig(golden_sig), .busy(busy_o[HI]), .done(done_o[HI]), .pass(pass_o[HI]),
        .fail(fail_o[HI]), .timeout(to_o[HI]), .signature(sig_o[HI]), .vec_count(cnt_o[HI]));

    // Reference model: chunk XOR of the response and one shift-register step.
    function automatic logic [31:0] m_fold(input logic [151:0] y);
        logic [31:0] f = 32'h0;
        for (int i = 0; i < 5; i++) f ^= 32'(y >> (32 * i));
        return f;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [31:0] f);
        logic [32:0] wide = {s, 1'b0};
        return wide[31:0] ^ (wide[32] ? POLY : 32'h0) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_end(input int idx, input string name, input logic [31:0] exp_sig,
                             input logic exp_pass, input logic exp_to);
        check({name, ".done"}, 32'(done_o[idx]), 32'd1);
        check({name, ".busy"}, 32'(busy_o[idx]), 32'd0);
        check({name, ".pass"}, 32'(pass_o[idx]), 32'(exp_pass));
        check({name, ".fail"}, 32'(fail_o[idx]), 32'(!exp_pass));
        check({name, ".timeout"}, 32'(to_o[idx]), 32'(exp_to));
        check({name, ".sig"}, sig_o[idx], exp_sig);
    endtask

    task automatic pulse_start(input int idx);
        start_i[idx] = 1'b1;
        tick();
        start_i[idx] = 1'b0;
    endtask

    function automatic logic [151:0] rand_y();
        logic [159:0] t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[151:0];
    endfunction

    typedef struct {
        logic [151:0] y;
        logic [31:0]  golden;
        logic [31:0]  exp_sig;
        logic         exp_pass;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0]  es, g;
        logic [151:0] y;
        logic [15:0]  ec;
        int           idle;
        logic         v, timed, good;

        tbl[0] = '{152'h0,                    32'h04C11DB7, 32'h04C11DB7, 1'b1};
        tbl[1] = '{152'h1,                    32'h00000000, 32'h04C11DB6, 1'b0};
        tbl[2] = '{152'h1_0000_0001,          32'h04C11DB7, 32'h04C11DB7, 1'b1};
        tbl[3] = '{152'h1 << 128,             32'h04C11DB6, 32'h04C11DB6, 1'b1};
        tbl[4] = '{{152{1'b1}},               32'h00000000, 32'h043EE248, 1'b0};
        tbl[5] = '{152'hDEAD_BEEF << 64,      32'hDA6CA358, 32'hDA6CA358, 1'b1};

        for (int i = 0; i < 4; i++) start_i[i] = 1'b0;
        y_in = '0; y_valid = 1'b0; golden_sig = '0; rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst.main.sig", sig_o[M], SEED_M);
        check("rst.hi.sig", sig_o[HI], 32'h8000_0000);
        check("rst.main.flags", {27'h0, busy_o[M], done_o[M], pass_o[M], fail_o[M], to_o[M]}, 32'h0);
        check("rst.main.cnt", 32'(cnt_o[M]), 32'h0);

        // Single-sample runs from a seed with the top bit set.
        for (int i = 0; i < 6; i++) begin
            pulse_start(HI);
            y_valid = 1'b1; y_in = tbl[i].y; golden_sig = tbl[i].golden;
            tick();
            y_valid = 1'b0;
            check($sformatf("tbl%0d.in_check", i), {30'h0, busy_o[HI], done_o[HI]}, 32'h2);
            tick();
            check_end(HI, $sformatf("tbl%0d", i), tbl[i].exp_sig, tbl[i].exp_pass, 1'b0);
        end

        // Twenty zero samples from zero seed; result two edges after last sample.
        pulse_start(Z20);
        y_valid = 1'b1; y_in = '0; golden_sig = 32'h0;
        repeat (20) tick();
        y_valid = 1'b0;
        check("z20.cnt", 32'(cnt_o[Z20]), 32'd20);
        check("z20.not_done_yet", 32'(done_o[Z20]), 32'd0);
        tick();
        check_end(Z20, "z20", 32'h0, 1'b1, 1'b0);

        // Two-sample runs: shift behaviour, mismatch, fold cancellation.
        pulse_start(Z2);
        y_valid = 1'b1; y_in = 152'h1;
        tick();
        check("z2.sig1", sig_o[Z2], 32'h1);
        y_in = 152'h0;
        tick();
        y_valid = 1'b0; golden_sig = 32'h3;
        check("z2.cnt", 32'(cnt_o[Z2]), 32'd2);
        tick();
        check_end(Z2, "z2.mismatch", 32'h2, 1'b0, 1'b0);
        tick();
        check("z2.held", sig_o[Z2], 32'h2);
        pulse_start(Z2);
        y_valid = 1'b1; y_in = 152'h1_0000_0001;
        repeat (2) tick();
        y_valid = 1'b0; golden_sig = 32'h0;
        tick();
        check_end(Z2, "z2.cancel", 32'h0, 1'b1, 1'b0);

        // Timeout after 16 idle cycles; no timeout with 14 or 15 idle cycles between samples.
        pulse_start(M);
        y_valid = 1'b0;
        repeat (15) tick();
        check("to.not_yet", 32'(done_o[M]), 32'd0);
        tick();
        check_end(M, "to", SEED_M, 1'b0, 1'b1);
        pulse_start(M);
        es = SEED_M;
        for (int k = 0; k < 3; k++) begin
            repeat (14) tick();
            y = rand_y(); y_valid = 1'b1; y_in = y;
            tick();
            y_valid = 1'b0;
            es = m_step(es, m_fold(y));
        end
        repeat (15) tick();
        y = rand_y(); y_valid = 1'b1; y_in = y;
        tick();
        y_valid = 1'b0;
        es = m_step(es, m_fold(y));
        check("gap.busy_no_to", {30'h0, busy_o[M], to_o[M]}, 32'h2);
        check("gap.cnt", 32'(cnt_o[M]), 32'd4);
        check("gap.sig", sig_o[M], es);

        // Reset in the middle of a run, then start in the middle of a run.
        pulse_start(M);
        y_valid = 1'b1; y_in = rand_y();
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; y_valid = 1'b0;
        check("midrst.flags", {27'h0, busy_o[M], done_o[M], pass_o[M], fail_o[M], to_o[M]}, 32'h0);
        check("midrst.sig", sig_o[M], SEED_M);
        check("midrst.cnt", 32'(cnt_o[M]), 32'd0);
        pulse_start(M);
        y_valid = 1'b1; y_in = rand_y();
        repeat (5) tick();
        check("midstart.pre_cnt", 32'(cnt_o[M]), 32'd5);
        start_i[M] = 1'b1;
        tick();
        start_i[M] = 1'b0; y_valid = 1'b0;
        check("midstart.cnt", 32'(cnt_o[M]), 32'd0);
        check("midstart.sig", sig_o[M], SEED_M);
        check("midstart.busy", 32'(busy_o[M]), 32'd1);

        // Randomized runs against the model; run 3 uses sparse valids to provoke timeouts.
        for (int r = 0; r < 10; r++) begin
            pulse_start(M);
            es = SEED_M; ec = 0; idle = 0; timed = 1'b0;
            for (int cyc = 0; cyc < 400 && ec < 16'd20 && !timed; cyc++) begin
                if (r == 3) v = ($urandom_range(0, 9) == 0);
                else v = (idle >= 14) ? 1'b1 : 1'($urandom_range(0, 1));
                y = rand_y(); y_valid = v; y_in = y;
                tick();
                if (v) begin
                    es = m_step(es, m_fold(y)); ec++; idle = 0;
                end else begin
                    idle++;
                    if (idle == 16) timed = 1'b1;
                end
                check($sformatf("rnd%0d.sig", r), sig_o[M], es);
                check($sformatf("rnd%0d.cnt", r), 32'(cnt_o[M]), 32'(ec));
            end
            y_valid = 1'b0;
            if (timed) begin
                check_end(M, $sformatf("rnd%0d.to", r), es, 1'b0, 1'b1);
            end else if (ec == 16'd20) begin
                check($sformatf("rnd%0d.in_check", r), {30'h0, busy_o[M], done_o[M]}, 32'h2);
                good = 1'($urandom_range(0, 1));
                g = good ? es : es ^ (32'h1 << $urandom_range(0, 31));
                golden_sig = g;
                tick();
                check_end(M, $sformatf("rnd%0d.end", r), es, good, 1'b0);
            end else begin
                check($sformatf("rnd%0d.cycle_budget", r), 32'(ec), 32'd20);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
